// File: rtl/ddr_test_sequencer_pkg.sv
// Shared types for the DDR test sequencer: command size encodings, FSM states,
// the command-table record and small helpers.
package ddr_test_sequencer_pkg;

  // Command size encodings; 2'b11 is never issued.
  localparam logic [1:0] SZ_32  = 2'b00;
  localparam logic [1:0] SZ_64  = 2'b01;
  localparam logic [1:0] SZ_256 = 2'b10;

  // Table addresses are stored at full width; the top keeps the low ADDR_W bits.
  localparam int unsigned CmdAddrW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap,
    StDone
  } seq_state_e;

  typedef struct packed {
    logic                we;
    logic [1:0]          size;
    logic [CmdAddrW-1:0] addr;
    logic [2:0]          sub;
  } cmd_entry_t;

  function automatic cmd_entry_t make_cmd(input logic                we,
                                          input logic [1:0]          size,
                                          input logic [CmdAddrW-1:0] addr,
                                          input logic [2:0]          sub);
    cmd_entry_t e;
    e.we   = we;
    e.size = size;
    e.addr = addr;
    e.sub  = sub;
    return e;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ddr_test_cmd_rom.sv
// Combinational command table: step index in, command entry out.
module ddr_test_cmd_rom
  import ddr_test_sequencer_pkg::*;
(
  input  logic [7:0] step_i,
  output cmd_entry_t entry_o
);

  // Fixed test table; steps beyond the table read back as a 256-bit read of row 0.
  always_comb begin
    entry_o = make_cmd(1'b0, SZ_256, 32'd0, 3'd0);
    case (step_i)
      8'd0:    entry_o = make_cmd(1'b1, SZ_256, 32'd0, 3'd0);
      8'd1:    entry_o = make_cmd(1'b0, SZ_256, 32'd0, 3'd0);
      8'd2:    entry_o = make_cmd(1'b1, SZ_64,  32'd0, 3'd2);
      8'd3:    entry_o = make_cmd(1'b1, SZ_32,  32'd0, 3'd5);
      8'd4:    entry_o = make_cmd(1'b1, SZ_256, 32'd0, 3'd7);
      8'd5:    entry_o = make_cmd(1'b1, SZ_256, 32'd1, 3'd7);
      8'd6:    entry_o = make_cmd(1'b0, SZ_256, 32'd0, 3'd0);
      8'd7:    entry_o = make_cmd(1'b0, SZ_256, 32'd1, 3'd0);
      8'd8:    entry_o = make_cmd(1'b0, SZ_256, 32'd2, 3'd0);
      8'd9:    entry_o = make_cmd(1'b0, SZ_256, 32'd3, 3'd0);
      default: ;
    endcase
  end

endmodule

// File: rtl/ddr_test_sequencer.sv
// DDR test sequencer: walks the command table LOOPS times per accepted start,
// one strobe per entry followed by GAP_CYCLES idle cycles, with a start cooldown.
// Optional read-data checking is compiled in with TEST_SEQ_CHECK_EN.
// ADDR_W must not exceed 32.
module ddr_test_sequencer
  import ddr_test_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 15,
  parameter int unsigned       NUM_STEPS  = 10,
  parameter int unsigned       GAP_CYCLES = 1,
  parameter int unsigned       LOOPS      = 1,
  parameter int unsigned       COOLDOWN   = 32'h0200_0000,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] PATTERN    = 32'hA5A5_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_startTest,
  input  logic              i_serverBusy,
  input  logic              i_dataValid,
  input  logic [DATA_W-1:0] i_readData,
  output logic              o_command,
  output logic              o_writeElseRead,
  output logic [1:0]        o_commandSize,
  output logic [ADDR_W-1:0] o_targetAddr,
  output logic [2:0]        o_subAddr,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_errCount
);

  seq_state_e        state_q, state_d;
  logic [7:0]        step_q, step_d;
  logic [15:0]       loop_q, loop_d;
  logic [31:0]       gap_q, gap_d;
  logic [31:0]       cool_q, cool_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        sub_q;
  logic              accept;
  logic              cmd_fire;
  cmd_entry_t        rom_entry;

  // Looking up the next step lets the fields be registered on entry to ISSUE.
  ddr_test_cmd_rom u_cmd_rom (
    .step_i  (step_d),
    .entry_o (rom_entry)
  );

  if (ADDR_W < CmdAddrW) begin : g_addr_trunc
    logic unused_addr_hi;
    assign unused_addr_hi = ^rom_entry.addr[CmdAddrW-1:ADDR_W];
  end

  assign accept = (state_q == StIdle) && i_startTest && (cool_q == '0);

  // Cooldown reloads on any start request, otherwise counts down to zero.
  always_comb begin
    cool_d = cool_q;
    if (i_startTest) begin
      cool_d = COOLDOWN;
    end else if (cool_q != '0) begin
      cool_d = cool_q - 32'd1;
    end
  end

  // Sequencer next-state: step/loop bookkeeping and the strobe decision.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    loop_d   = loop_q;
    gap_d    = gap_q;
    cmd_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          step_d  = '0;
          loop_d  = '0;
        end
      end
      StIssue: begin
        if (!i_serverBusy) begin
          cmd_fire = 1'b1;
          state_d  = StGap;
          gap_d    = '0;
        end
      end
      StGap: begin
        if (gap_q == 32'(GAP_CYCLES - 1)) begin
          if (step_q != 8'(NUM_STEPS - 1)) begin
            state_d = StIssue;
            step_d  = step_q + 8'd1;
          end else if (loop_q != 16'(LOOPS - 1)) begin
            state_d = StIssue;
            step_d  = '0;
            loop_d  = loop_q + 16'd1;
          end else begin
            state_d = StDone;
          end
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and the held command fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      loop_q  <= '0;
      gap_q   <= '0;
      cool_q  <= COOLDOWN;
      we_q    <= 1'b1;
      size_q  <= SZ_32;
      addr_q  <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      loop_q  <= loop_d;
      gap_q   <= gap_d;
      cool_q  <= cool_d;
      if (state_d == StIssue) begin
        we_q   <= rom_entry.we;
        size_q <= rom_entry.size;
        addr_q <= rom_entry.addr[ADDR_W-1:0];
        sub_q  <= rom_entry.sub;
      end
    end
  end

  // A reset cycle never emits a strobe, even if the FSM was in ISSUE.
  assign o_command       = cmd_fire & ~i_rst;
  assign o_writeElseRead = we_q;
  assign o_commandSize   = size_q;
  assign o_targetAddr    = addr_q;
  assign o_subAddr       = sub_q;
  assign o_ready         = (cool_q == '0);
  assign o_busy          = (state_q != StIdle);
  assign o_done          = (state_q == StDone);

`ifdef TEST_SEQ_CHECK_EN
  logic [DATA_W-1:0] resp_idx_q, resp_idx_d;
  logic [DATA_W-1:0] exp_word;
  logic [15:0]       err_q, err_d;

  // Expected word is the seed plus the response ordinal since the last accepted start.
  always_comb begin
    exp_word   = PATTERN + resp_idx_q;
    resp_idx_d = resp_idx_q;
    err_d      = err_q;
    if (accept) begin
      resp_idx_d = '0;
      err_d      = '0;
    end else if (i_dataValid) begin
      resp_idx_d = resp_idx_q + DATA_W'(1);
      if (i_readData != exp_word) begin
        err_d = sat_inc16(err_q);
      end
    end
  end

  // Response index and saturating error counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      resp_idx_q <= '0;
      err_q      <= '0;
    end else begin
      resp_idx_q <= resp_idx_d;
      err_q      <= err_d;
    end
  end

  assign o_errCount = err_q;
`else
  logic unused_rd;
  assign unused_rd  = ^{i_dataValid, i_readData};
  assign o_errCount = '0;
`endif

endmodule

// File: tb/tb_ddr_test_sequencer.sv
// Directed bench for ddr_test_sequencer: cooldown, table walk, busy stall,
// multi-loop gap spacing, mid-sequence reset and (optionally) read checking.
module tb_ddr_test_sequencer;

  localparam int unsigned AddrW   = 15;
  localparam logic [31:0] Pattern = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, busy_a, dv_a, start_b;
  logic [31:0] rd_a;

  logic             cmd_a, we_a, ready_a, busyo_a, done_a;
  logic [1:0]       size_a;
  logic [AddrW-1:0] addr_a;
  logic [2:0]       sub_a;
  logic [15:0]      err_a;

  logic             cmd_b, we_b, ready_b, busyo_b, done_b;
  logic [1:0]       size_b;
  logic [AddrW-1:0] addr_b;
  logic [2:0]       sub_b;
  logic [15:0]      err_b;

  int n_assert = 0;
  int n_fail   = 0;

  ddr_test_sequencer #(
    .ADDR_W(AddrW), .NUM_STEPS(10), .GAP_CYCLES(1), .LOOPS(1), .COOLDOWN(4),
    .DATA_W(32), .PATTERN(Pattern)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_startTest(start_a), .i_serverBusy(busy_a),
    .i_dataValid(dv_a), .i_readData(rd_a), .o_command(cmd_a), .o_writeElseRead(we_a),
    .o_commandSize(size_a), .o_targetAddr(addr_a), .o_subAddr(sub_a), .o_ready(ready_a),
    .o_busy(busyo_a), .o_done(done_a), .o_errCount(err_a)
  );

  ddr_test_sequencer #(
    .ADDR_W(AddrW), .NUM_STEPS(10), .GAP_CYCLES(3), .LOOPS(3), .COOLDOWN(4),
    .DATA_W(32), .PATTERN(Pattern)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_startTest(start_b), .i_serverBusy(1'b0),
    .i_dataValid(1'b0), .i_readData(32'd0), .o_command(cmd_b), .o_writeElseRead(we_b),
    .o_commandSize(size_b), .o_targetAddr(addr_b), .o_subAddr(sub_b), .o_ready(ready_b),
    .o_busy(busyo_b), .o_done(done_b), .o_errCount(err_b)
  );

  // Strobe monitor, sampled on the falling edge.
  int          cyc = 0;
  int          a_n = 0, a_done = 0, a_done_cyc = 0, a_b2b = 0;
  logic        a_prev = 1'b0;
  int          a_cyc [256];
  logic [20:0] a_fld [256];
  int          b_n = 0, b_done = 0, b_viol = 0, b_last = -100;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    a_prev <= cmd_a;
    if (cmd_a && a_prev) a_b2b <= a_b2b + 1;
    if (cmd_a && a_n < 256) begin
      a_cyc[a_n] <= cyc;
      a_fld[a_n] <= {we_a, size_a, addr_a, sub_a};
      a_n        <= a_n + 1;
    end
    if (done_a) begin
      a_done     <= a_done + 1;
      a_done_cyc <= cyc;
    end
    if (cmd_b) begin
      b_n    <= b_n + 1;
      b_last <= cyc;
      if (cyc - b_last < 4) b_viol <= b_viol + 1;
    end
    if (done_b) b_done <= b_done + 1;
  end

  // Expected table entry {we, size, addr, sub}.
  function automatic logic [20:0] exp_fld(input int i);
    case (i)
      0:       return {1'b1, 2'b10, 15'd0, 3'd0};
      1:       return {1'b0, 2'b10, 15'd0, 3'd0};
      2:       return {1'b1, 2'b01, 15'd0, 3'd2};
      3:       return {1'b1, 2'b00, 15'd0, 3'd5};
      4:       return {1'b1, 2'b10, 15'd0, 3'd7};
      5:       return {1'b1, 2'b10, 15'd1, 3'd7};
      6:       return {1'b0, 2'b10, 15'd0, 3'd0};
      7:       return {1'b0, 2'b10, 15'd1, 3'd0};
      8:       return {1'b0, 2'b10, 15'd2, 3'd0};
      default: return {1'b0, 2'b10, 15'd3, 3'd0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done_a(input int base, input int limit);
    int k = 0;
    while (a_done == base && k < limit) begin
      tick();
      k++;
    end
    check("a_done_seen", 64'(a_done != base), 64'd1);
  endtask

  task automatic wait_ready_a(input int limit);
    int k = 0;
    while (!ready_a && k < limit) begin
      tick();
      k++;
    end
    check("a_ready_seen", 64'(ready_a), 64'd1);
  endtask

  task automatic check_table_a(input string tag, input int base);
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_fld[base + i] !== exp_fld(i)) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base_n, base_d, bad_sp;
    rst = 1'b1; start_a = 1'b0; busy_a = 1'b0; dv_a = 1'b0; rd_a = '0; start_b = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_cmd",   64'(cmd_a),   64'd0);
    check("rst_we",    64'(we_a),    64'd1);
    check("rst_size",  64'(size_a),  64'd0);
    check("rst_addr",  64'(addr_a),  64'd0);
    check("rst_sub",   64'(sub_a),   64'd0);
    check("rst_done",  64'(done_a),  64'd0);
    check("rst_busy",  64'(busyo_a), 64'd0);
    check("rst_ready", 64'(ready_a), 64'd0);
    check("rst_err",   64'(err_a),   64'd0);

    // Start during cooldown: ignored, but reloads the counter.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    #1;
    check("cool_no_accept", 64'(busyo_a), 64'd0);
    n = 0;
    while (!ready_a && n < 10) begin
      n++;
      tick();
    end
    check("cool_low_cycles", 64'(n), 64'd4);
    check("cool_still_idle", 64'(busyo_a), 64'd0);

    // Full pass, server never busy.
    base_n = a_n; base_d = a_done;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("run1_busy", 64'(busyo_a), 64'd1);
    check("run1_ready_low", 64'(ready_a), 64'd0);
    wait_done_a(base_d, 60);
    repeat (5) tick();
    check("run1_strobes", 64'(a_n - base_n), 64'd10);
    check_table_a("run1_fields", base_n);
    bad_sp = 0;
    for (int i = 1; i < 10; i++) begin
      if (a_cyc[base_n + i] - a_cyc[base_n + i - 1] != 2) bad_sp++;
    end
    check("run1_spacing", 64'(bad_sp), 64'd0);
    check("run1_third", 64'(a_fld[base_n + 2]), 64'({1'b1, 2'b01, 15'd0, 3'd2}));
    check("run1_done_cnt", 64'(a_done - base_d), 64'd1);
    check("run1_done_pos", 64'(a_done_cyc - a_cyc[base_n + 9]), 64'd2);
    check("run1_b2b", 64'(a_b2b), 64'd0);
    check("run1_hold_addr", 64'(addr_a), 64'd3);
    check("run1_hold_we", 64'(we_a), 64'd0);
    check("run1_idle", 64'(busyo_a), 64'd0);

    // Server busy for 5 cycles during ISSUE of step 3.
    base_n = a_n; base_d = a_done;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    busy_a = 1'b1;
    #1;
    check("busy_fields_sub", 64'(sub_a), 64'd5);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("busy_no_strobe", 64'(cmd_a), 64'd0);
      tick();
    end
    busy_a = 1'b0;
    #1;
    check("busy_release_strobe", 64'(cmd_a), 64'd1);
    check("busy_release_fields", 64'({we_a, size_a, addr_a, sub_a}), 64'(exp_fld(3)));
    wait_done_a(base_d, 80);
    check("busy_strobes", 64'(a_n - base_n), 64'd10);
    check_table_a("busy_fields", base_n);
    check("busy_stall_gap", 64'(a_cyc[base_n + 3] - a_cyc[base_n + 2]), 64'd7);

    // Three loops with three gap cycles on the second instance.
    base_n = b_n; base_d = b_done;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (b_done == base_d && n < 400) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("loop_strobes", 64'(b_n - base_n), 64'd30);
    check("loop_gap_viol", 64'(b_viol), 64'd0);
    check("loop_done_cnt", 64'(b_done - base_d), 64'd1);

    // Reset at step 5 aborts the pass.
    base_n = a_n; base_d = a_done;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (10) tick();
    #1;
    check("pre_rst_step5", 64'({addr_a, sub_a}), 64'({15'd1, 3'd7}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_cmd",  64'(cmd_a),   64'd0);
    check("post_rst_we",   64'(we_a),    64'd1);
    check("post_rst_busy", 64'(busyo_a), 64'd0);
    check("post_rst_addr", 64'(addr_a),  64'd0);
    repeat (30) tick();
    check("post_rst_strobes", 64'(a_n - base_n), 64'd5);
    check("post_rst_no_done", 64'(a_done - base_d), 64'd0);

    // Read-data checking.
    wait_ready_a(10);
    rd_a = 32'h0000_1234;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    base_d = a_done;
    dv_a = 1'b1;
    rd_a = Pattern;
    tick();
    rd_a = Pattern + 32'd1;
    tick();
    rd_a = 32'd0;
    tick();
    dv_a = 1'b0;
    #1;
`ifdef TEST_SEQ_CHECK_EN
    check("err_one", 64'(err_a), 64'd1);
`else
    check("err_tied", 64'(err_a), 64'd0);
`endif
    wait_done_a(base_d, 60);
    wait_ready_a(10);
    dv_a = 1'b1;
    rd_a = 32'd0;
    tick();
    dv_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    #1;
    check("err_cleared", 64'(err_a), 64'd0);
    dv_a = 1'b1;
    rd_a = Pattern;
    tick();
    dv_a = 1'b0;
    #1;
    check("err_index_restart", 64'(err_a), 64'd0);
    base_d = a_done;
    wait_done_a(base_d, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_test_sequencer.md
DDR_TEST_SEQUENCER -- requirements
Module: ddr_test_sequencer

Interface
REQ-001 Parameter ADDR_W, 15, width of o_targetAddr.
REQ-002 Parameter NUM_STEPS, 10, command-table entries executed per pass (1..256).
REQ-003 Parameter GAP_CYCLES, 1, idle cycles with o_command low after each issued command (>=1).
REQ-004 Parameter LOOPS, 1, full table passes per accepted start (1..65535).
REQ-005 Parameter COOLDOWN, 32'h0200_0000, cycles o_ready stays low after i_startTest is seen.
REQ-006 Parameter DATA_W, 32, read-data width.
REQ-007 Parameter PATTERN, 32'hA5A5_0000, seed of the expected read-data pattern.
REQ-008 i_clk  in  1  the one clock; all logic on rising edge.
REQ-009 i_rst  in  1  reset, synchronous, active-high.
REQ-010 i_startTest  in  1  start request / cooldown reload.
REQ-011 i_serverBusy  in  1  server cannot accept a command this cycle.
REQ-012 i_dataValid  in  1  i_readData holds a read response word.
REQ-013 i_readData  in  DATA_W  read response data.
REQ-014 o_command  out  1  one-cycle command strobe.
REQ-015 o_writeElseRead  out  1  1 = write, 0 = read.
REQ-016 o_commandSize  out  2  00 = 32-bit, 01 = 64-bit, 10 = 256-bit; 11 never driven.
REQ-017 o_targetAddr  out  ADDR_W  256-bit row address.
REQ-018 o_subAddr  out  3  32-bit word within the row.
REQ-019 o_ready  out  1  high when cooldown counter == 0.
REQ-020 o_busy  out  1  high in any state other than IDLE.
REQ-021 o_done  out  1  one-cycle pulse when the final pass completes.
REQ-022 o_errCount  out  16  read-data mismatch count.

Function
REQ-023 States: IDLE, ISSUE, GAP, DONE. Step index (0..NUM_STEPS-1) and loop counter are both registers.
REQ-024 IDLE: if i_startTest && cooldown == 0 in the same cycle, go to ISSUE with step = 0 and loop = 0; otherwise stay in IDLE.
REQ-025 ISSUE: drive the command fields from the table entry for the current step. If !i_serverBusy, assert o_command for exactly one cycle and go to GAP; otherwise keep o_command = 0 and stay in ISSUE.
REQ-026 GAP: hold o_command = 0 for GAP_CYCLES cycles, then advance. o_command is never high two cycles in a row.
REQ-027 Advance: if step < NUM_STEPS-1, go to ISSUE with step+1.
REQ-028 Advance on the last step: if loop < LOOPS-1, go to ISSUE with step = 0 and loop+1; otherwise go to DONE.
REQ-029 DONE: pulse o_done for one cycle, then go to IDLE.
REQ-030 Command fields hold their last values while not in ISSUE.
REQ-031 Cooldown counter: loads COOLDOWN whenever i_startTest = 1, in any state. Otherwise it decrements by 1 down to 0 and stays at 0.
REQ-032 i_startTest outside IDLE is ignored apart from the cooldown reload.
REQ-033 i_serverBusy during GAP has no effect.

Reset
REQ-034 While i_rst = 1 at a clock edge, the block resets to the values below; reset mid-sequence aborts it with no further strobe.
REQ-035 Reset values: state IDLE; o_command 0; o_writeElseRead 1; o_commandSize 00; o_targetAddr 0; o_subAddr 000; o_done 0; o_errCount 0; step and loop 0.
REQ-036 Reset loads the cooldown counter with COOLDOWN, so o_ready = 0 after reset.

Configuration
REQ-037 Macro TEST_SEQ_CHECK_EN, when defined, compiles in read-data checking.
REQ-038 With the macro: each i_dataValid cycle compares i_readData against PATTERN + response index (DATA_W-bit wrap); the response index counts from 0 after each accepted start.
REQ-039 With the macro: each mismatch increments o_errCount, saturating at 16'hFFFF. Accepting a start clears o_errCount and the response index.
REQ-040 Without the macro: o_errCount is tied to 0 and i_readData and i_dataValid are unused.

Structure
REQ-041 A shared package holds the size encodings (SZ_32 = 00, SZ_64 = 01, SZ_256 = 10), the state enumeration and the command-entry record {we, size, addr, sub}.
REQ-042 Sub-module ddr_test_cmd_rom: combinational, step index in, command entry out. Default table, 10 entries, in this order:
- W256 0/0
- R256 0/0
- W64 0/2
- W32 0/5
- W256 0/7
- W256 1/7
- R256 0/0
- R256 1/0
- R256 2/0
- R256 3/0

Verification
REQ-043 COOLDOWN = 4: after reset, i_startTest held 1 cycle -> o_ready low 4 cycles, then high; a start during cooldown is not accepted.
REQ-044 Default table, server never busy, GAP_CYCLES = 1 -> 10 strobes spaced 2 cycles apart; the 3rd strobe has we = 1, size = 01, addr = 0, sub = 2; o_done pulses once after the 10th strobe.
REQ-045 i_serverBusy high 5 cycles during ISSUE of step 3 -> no strobe for those 5 cycles; the strobe comes on the first not-busy cycle with fields unchanged.
REQ-046 LOOPS = 3, GAP_CYCLES = 3 -> 30 strobes, each followed by at least 3 low cycles, and one o_done.
REQ-047 i_rst asserted at step 5 -> next cycle in IDLE, o_command = 0, o_writeElseRead = 1; no further strobes.
REQ-048 With TEST_SEQ_CHECK_EN: responses PATTERN+0, PATTERN+1, then 0 -> o_errCount = 1; the next accepted start clears it to 0.
